// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and constants for the data-memory arbiter.
package dmem_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    // Low address bits that must be zero for a word access.
    localparam logic [1:0] ALIGN_MASK = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_e;

    // True when an access must be rejected: misaligned or past the last legal word.
    function automatic logic addr_bad(input logic [ADDR_W-1:0] addr,
                                      input logic [ADDR_W-1:0] max_addr);
        return ((addr[1:0] & ALIGN_MASK) != 2'b00) || (addr > max_addr);
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: combinational two-way arbiter, round-robin or fixed priority.
module rr_arbiter2
    import dmem_pkg::*;
(
    input  logic [1:0] req_i,
    input  logic       last_grant_i,
    input  logic       fixed_prio_i,
    output logic       grant_o,
    output logic       valid_o
);

    // Pick the winner; on a tie prefer port 0 in fixed mode, else the port not served last.
    always_comb begin
        valid_o = |req_i;
        grant_o = 1'b0;
        case (req_i)
            2'b01:   grant_o = 1'b0;
            2'b10:   grant_o = 1'b1;
            2'b11:   grant_o = fixed_prio_i ? 1'b0 : ~last_grant_i;
            default: grant_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: serialises two requesters onto the word-access data memory,
// holds the strobes for a fixed window and returns a one-cycle ready/err.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int ACCESS_CYCLES = 2,
    parameter int MEM_BYTES     = 256,
    parameter int FIXED_PRIO    = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic              p0_ready,
    output logic              p0_err,
    output logic [DATA_W-1:0] p0_rdata,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_ready,
    output logic              p1_err,
    output logic [DATA_W-1:0] p1_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_read,
    output logic              mem_write,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    localparam logic [3:0]        CNT_LAST = 4'(ACCESS_CYCLES - 1);
    localparam logic [ADDR_W-1:0] MAX_ADDR = ADDR_W'(MEM_BYTES - 4);
    localparam logic              FIXED    = (FIXED_PRIO != 0);

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              last_grant_q, last_grant_d;
    logic              grant_q, grant_d;
    logic              we_q, we_d;
    logic              err_q, err_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    logic              arb_grant;
    logic              arb_valid;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              in_access;
    logic              in_resp;

    rr_arbiter2 u_arb (
        .req_i        ({p1_req, p0_req}),
        .last_grant_i (last_grant_q),
        .fixed_prio_i (FIXED),
        .grant_o      (arb_grant),
        .valid_o      (arb_valid)
    );

    // Route the winning requester's command fields toward the latches.
    always_comb begin
        sel_we    = arb_grant ? p1_we    : p0_we;
        sel_addr  = arb_grant ? p1_addr  : p0_addr;
        sel_wdata = arb_grant ? p1_wdata : p0_wdata;
    end

    // State and datapath registers; reset leaves port 0 the winner of the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= 4'd0;
            last_grant_q <= 1'b1;
            grant_q      <= 1'b0;
            we_q         <= 1'b0;
            err_q        <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_grant_q <= last_grant_d;
            grant_q      <= grant_d;
            we_q         <= we_d;
            err_q        <= err_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rdata_q      <= rdata_d;
        end
    end

    // Next-state: grant and latch in IDLE, count the strobe window, then respond once.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        last_grant_d = last_grant_q;
        grant_d      = grant_q;
        we_d         = we_q;
        err_d        = err_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        rdata_d      = rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (arb_valid) begin
                    grant_d = arb_grant;
                    we_d    = sel_we;
                    addr_d  = sel_addr;
                    wdata_d = sel_wdata;
                    rdata_d = '0;
                    cnt_d   = 4'd0;
                    if (addr_bad(sel_addr, MAX_ADDR)) begin
                        err_d   = 1'b1;
                        state_d = ST_RESP;
                    end else begin
                        err_d   = 1'b0;
                        state_d = ST_ACCESS;
                    end
                end
            end
            ST_ACCESS: begin
                if (cnt_q == CNT_LAST) begin
                    // Memory output settled on the preceding negedge.
                    if (!we_q) begin
                        rdata_d = mem_rdata;
                    end
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            ST_RESP: begin
                last_grant_d = grant_q;
                state_d      = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs decode straight from registered state so reset clears them at once.
    always_comb begin
        in_access = (state_q == ST_ACCESS);
        in_resp   = (state_q == ST_RESP);
        busy      = (state_q != ST_IDLE);
        mem_read  = in_access & ~we_q;
        mem_write = in_access & we_q;
        mem_addr  = in_access ? addr_q  : '0;
        mem_wdata = in_access ? wdata_q : '0;
        p0_ready  = in_resp & ~err_q & ~grant_q;
        p0_err    = in_resp &  err_q & ~grant_q;
        p1_ready  = in_resp & ~err_q &  grant_q;
        p1_err    = in_resp &  err_q &  grant_q;
        p0_rdata  = (in_resp & ~err_q & ~we_q & ~grant_q) ? rdata_q : '0;
        p1_rdata  = (in_resp & ~err_q & ~we_q &  grant_q) ? rdata_q : '0;
    end

endmodule
